// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Strobes are combinational from state and inputs. State, halt flag and
// performance counters are registered.
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_req,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        de_dREN,
    input  logic [4:0]  de_wsel,
    input  logic        br_taken,
    input  logic        halt_in,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        em_en,
    output logic        mw_en,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               load_use_c;
    logic               flush_evt_c;

    // Load-use hazard: load in ID/EX writes a non-zero register read by IF/ID.
    assign load_use_c = de_dREN && (de_wsel != 5'd0) &&
                        ((de_wsel == fd_rs) || (de_wsel == fd_rt));

    // Priority-ordered strobe generation and next-state/counter computation.
    always_comb begin
        state_d     = state_q;
        halted_d    = halted_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        flush_evt_c = 1'b0;
        pc_en       = 1'b0;
        fd_en       = 1'b0;
        de_en       = 1'b0;
        em_en       = 1'b0;
        mw_en       = 1'b0;
        fd_flush    = 1'b0;
        de_flush    = 1'b0;
        em_flush    = 1'b0;

        if (state_q == S_HALT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
        end else if (halt_in) begin
            mw_en    = 1'b1;
            state_d  = S_HALT;
            halted_d = 1'b1;
        end else if (mem_req && !dhit) begin
            state_d = S_DWAIT;
        end else begin
            state_d = S_RUN;
            fd_en   = 1'b1;
            de_en   = 1'b1;
            em_en   = 1'b1;
            mw_en   = 1'b1;
            if (br_taken) begin
                pc_en       = 1'b1;
                fd_flush    = 1'b1;
                de_flush    = 1'b1;
                em_flush    = 1'b1;
                flush_evt_c = 1'b1;
            end else if (load_use_c) begin
                fd_en    = 1'b0;
                de_flush = 1'b1;
            end else if (!ihit) begin
                fd_flush = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end

        if ((state_q != S_HALT) && !pc_en && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_evt_c && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State, sticky halt and saturating counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_RUN;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
